fp_stream_accumulator: RTL



---
 rtl/fp_stream_accumulator_if.sv | 25 ++
 rtl/fp_stream_accumulator.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_stream_accumulator_if.sv
// Stream/result bundle for fp_stream_accumulator: run control, element input
// stream and held result.
interface fp_stream_accumulator_if #(parameter int CNT_W = 16);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             ovf_sticky;
    logic             unf_sticky;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_count, ovf_sticky, unf_sticky, busy
    );
    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_count, ovf_sticky, unf_sticky, busy
    );
endinterface

// File: rtl/fp_stream_accumulator.sv
// fp32 run accumulator around a single-cycle fp_adder (IDLE/ACCUM/DONE).
// Optional macro FP_ACC_SATURATE_EN: saturate to +/-inf or +/-0 and freeze after overflow.
module fp_adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum,
    output logic        overflow,
    output logic        underflow
);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [27:0] mb, ms, s;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        found;

    // Truncating adder; denormal inputs count as zero, exceptions return 0.5.
    always_comb begin
        if (A[30:0] >= B[30:0]) begin big = A; sml = B; end
        else                    begin big = B; sml = A; end
        eb = big[30:23];
        es = sml[30:23];
        mb = (eb == 8'd0) ? 28'd0 : {2'b01, big[22:0], 3'b000};
        ms = (es == 8'd0) ? 28'd0 : {2'b01, sml[22:0], 3'b000};
        d  = eb - es;
        ms = (d > 8'd26) ? 28'd0 : (ms >> d);
        s  = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
        e  = {2'b00, eb};
        lz = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (s[i]) found = 1'b1;
                else      lz = lz + 5'd1;
            end
        end
        overflow  = 1'b0;
        underflow = 1'b0;
        Sum       = 32'h0;
        if (s != 28'd0) begin
            if (s[27]) begin
                s = s >> 1;
                e = e + 10'd1;
            end else begin
                s = s << lz;
                e = e - {5'd0, lz};
            end
            if (e[9] || e == 10'd0)  underflow = 1'b1;
            else if (e >= 10'd255)   overflow  = 1'b1;
            else                     Sum = {big[31], e[7:0], s[25:3]};
            if (overflow || underflow) Sum = 32'h3F00_0000;
        end
    end
endmodule

module fp_stream_accumulator #(parameter int CNT_W = 16) (
    input  logic                  clk,
    input  logic                  rst,
    fp_stream_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] len_q, cnt_q, cnt_d;
    logic [31:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             in_ready_q, out_valid_q;
    logic [31:0]      add_sum;
    logic             add_ovf, add_unf;

    fp_adder u_add (
        .A         (acc_q),
        .B         (bus.in_data),
        .Sum       (add_sum),
        .overflow  (add_ovf),
        .underflow (add_unf)
    );

    // First element of a run loads directly so the adder never sees a stale acc.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (cnt_q == '0) begin
            acc_d = bus.in_data;
        end else begin
            ovf_d = ovf_q | add_ovf;
            unf_d = unf_q | add_unf;
`ifdef FP_ACC_SATURATE_EN
            if (ovf_q)        acc_d = acc_q;
            else if (add_ovf) acc_d = {bus.in_data[31], 8'hFF, 23'h0};
            else if (add_unf) acc_d = {bus.in_data[31], 31'h0};
            else              acc_d = add_sum;
`else
            acc_d = add_sum;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= 32'h0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    len_q <= bus.len;
                    cnt_q <= '0;
                    acc_q <= 32'h0;
                    ovf_q <= 1'b0;
                    unf_q <= 1'b0;
                    if (bus.len == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b1;
                    end
                end
                ACCUM: if (bus.in_valid && in_ready_q) begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    unf_q <= unf_d;
                    if (cnt_d == len_q) begin
                        state_q     <= DONE;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = acc_q;
    assign bus.out_count  = cnt_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.unf_sticky = unf_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
